// File: rtl/operand_pair_aligner.sv
// Re-pairs two independent valid-qualified streams in arrival order using one
// elastic FIFO per side, emitting matched operand pairs with a single strobe.
module operand_pair_aligner #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [WIDTH-1:0]  a,
  input  logic              data_available_a,
  input  logic [WIDTH-1:0]  b,
  input  logic              data_available_b,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic              data_available_out,
  output logic [ADDR_W:0]   level_a,
  output logic [ADDR_W:0]   level_b,
  output logic              overflow_a,
  output logic              overflow_b
);

  localparam logic [ADDR_W:0]   LVL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]  mem_a_q [DEPTH];
  logic [WIDTH-1:0]  mem_b_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_a_q, wr_ptr_a_d, rd_ptr_a_q, rd_ptr_a_d;
  logic [ADDR_W-1:0] wr_ptr_b_q, wr_ptr_b_d, rd_ptr_b_q, rd_ptr_b_d;
  logic [ADDR_W:0]   level_a_q, level_a_d, level_b_q, level_b_d;
  logic              ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
  logic [WIDTH-1:0]  out_a_q, out_a_d, out_b_q, out_b_d;
  logic              dav_q, dav_d;

  logic              nonempty_a_s, nonempty_b_s, pair_s;
  logic              push_a_s, push_b_s, pop_a_s, pop_b_s;
  logic              drop_a_s, drop_b_s;
  logic [WIDTH-1:0]  head_a_s, head_b_s;

  // An empty side bypasses the incoming word straight to the pair; a full side
  // may still accept a word when it pops in the same cycle.
  always_comb begin
    nonempty_a_s = (level_a_q != LVL_ZERO);
    nonempty_b_s = (level_b_q != LVL_ZERO);
    head_a_s     = nonempty_a_s ? mem_a_q[rd_ptr_a_q] : a;
    head_b_s     = nonempty_b_s ? mem_b_q[rd_ptr_b_q] : b;
    pair_s       = (nonempty_a_s | data_available_a) & (nonempty_b_s | data_available_b);
    pop_a_s      = pair_s & nonempty_a_s;
    pop_b_s      = pair_s & nonempty_b_s;
    push_a_s     = data_available_a & (pair_s ? nonempty_a_s : (level_a_q != LVL_FULL));
    push_b_s     = data_available_b & (pair_s ? nonempty_b_s : (level_b_q != LVL_FULL));
    drop_a_s     = data_available_a & ~pair_s & (level_a_q == LVL_FULL);
    drop_b_s     = data_available_b & ~pair_s & (level_b_q == LVL_FULL);
  end

  // Next-state for pointers, levels, sticky flags and output registers.
  always_comb begin
    wr_ptr_a_d = wr_ptr_a_q;
    rd_ptr_a_d = rd_ptr_a_q;
    wr_ptr_b_d = wr_ptr_b_q;
    rd_ptr_b_d = rd_ptr_b_q;
    level_a_d  = level_a_q;
    level_b_d  = level_b_q;
    ovf_a_d    = ovf_a_q;
    ovf_b_d    = ovf_b_q;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    dav_d      = 1'b0;
    if (flush) begin
      wr_ptr_a_d = PTR_ZERO;
      rd_ptr_a_d = PTR_ZERO;
      wr_ptr_b_d = PTR_ZERO;
      rd_ptr_b_d = PTR_ZERO;
      level_a_d  = LVL_ZERO;
      level_b_d  = LVL_ZERO;
      ovf_a_d    = 1'b0;
      ovf_b_d    = 1'b0;
    end else begin
      if (push_a_s) wr_ptr_a_d = wr_ptr_a_q + PTR_ONE;
      else          wr_ptr_a_d = wr_ptr_a_q;
      if (pop_a_s)  rd_ptr_a_d = rd_ptr_a_q + PTR_ONE;
      else          rd_ptr_a_d = rd_ptr_a_q;
      if (push_b_s) wr_ptr_b_d = wr_ptr_b_q + PTR_ONE;
      else          wr_ptr_b_d = wr_ptr_b_q;
      if (pop_b_s)  rd_ptr_b_d = rd_ptr_b_q + PTR_ONE;
      else          rd_ptr_b_d = rd_ptr_b_q;
      case ({push_a_s, pop_a_s})
        2'b10:   level_a_d = level_a_q + LVL_ONE;
        2'b01:   level_a_d = level_a_q - LVL_ONE;
        default: level_a_d = level_a_q;
      endcase
      case ({push_b_s, pop_b_s})
        2'b10:   level_b_d = level_b_q + LVL_ONE;
        2'b01:   level_b_d = level_b_q - LVL_ONE;
        default: level_b_d = level_b_q;
      endcase
      ovf_a_d = ovf_a_q | drop_a_s;
      ovf_b_d = ovf_b_q | drop_b_s;
      if (pair_s) begin
        out_a_d = head_a_s;
        out_b_d = head_b_s;
        dav_d   = 1'b1;
      end else begin
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        dav_d   = 1'b0;
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_a_q <= PTR_ZERO;
      rd_ptr_a_q <= PTR_ZERO;
      wr_ptr_b_q <= PTR_ZERO;
      rd_ptr_b_q <= PTR_ZERO;
      level_a_q  <= LVL_ZERO;
      level_b_q  <= LVL_ZERO;
      ovf_a_q    <= 1'b0;
      ovf_b_q    <= 1'b0;
      out_a_q    <= {WIDTH{1'b0}};
      out_b_q    <= {WIDTH{1'b0}};
      dav_q      <= 1'b0;
    end else begin
      wr_ptr_a_q <= wr_ptr_a_d;
      rd_ptr_a_q <= rd_ptr_a_d;
      wr_ptr_b_q <= wr_ptr_b_d;
      rd_ptr_b_q <= rd_ptr_b_d;
      level_a_q  <= level_a_d;
      level_b_q  <= level_b_d;
      ovf_a_q    <= ovf_a_d;
      ovf_b_q    <= ovf_b_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      dav_q      <= dav_d;
    end
  end

  // Storage is not reset; writes are suppressed under reset and flush.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_a_s) mem_a_q[wr_ptr_a_q] <= a;
    if (rst_n && !flush && push_b_s) mem_b_q[wr_ptr_b_q] <= b;
  end

  assign out_a              = out_a_q;
  assign out_b              = out_b_q;
  assign data_available_out = dav_q;
  assign level_a            = level_a_q;
  assign level_b            = level_b_q;
  assign overflow_a         = ovf_a_q;
  assign overflow_b         = ovf_b_q;

endmodule

// File: tb/tb_operand_pair_aligner.sv
// Directed bench for operand_pair_aligner: a queue-based pairing model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_operand_pair_aligner;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] a = 32'h0, b = 32'h0;
  logic             va = 1'b0, vb = 1'b0;
  logic [WIDTH-1:0] out_a, out_b;
  logic             dav;
  logic [ADDR_W:0]  level_a, level_b;
  logic             overflow_a, overflow_b;

  int total = 0;
  int bad   = 0;

  operand_pair_aligner #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a(a), .data_available_a(va), .b(b), .data_available_b(vb),
    .out_a(out_a), .out_b(out_b), .data_available_out(dav),
    .level_a(level_a), .level_b(level_b),
    .overflow_a(overflow_a), .overflow_b(overflow_b)
  );

  always #5 clk = ~clk;

  // Reference model: two queues paired in arrival order.
  logic [WIDTH-1:0] qa[$], qb[$];
  logic [WIDTH-1:0] m_out_a, m_out_b;
  logic             m_dav, m_ovf_a, m_ovf_b;
  bit               m_valid = 1'b0;

  always @(posedge clk) begin
    logic [WIDTH-1:0] ha, hb;
    bit av, bv;
    if (!rst_n) begin
      qa.delete(); qb.delete();
      m_out_a = '0; m_out_b = '0; m_dav = 1'b0;
      m_ovf_a = 1'b0; m_ovf_b = 1'b0;
      m_valid = 1'b1;
    end else if (flush) begin
      qa.delete(); qb.delete();
      m_dav = 1'b0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    end else begin
      av = (qa.size() != 0) || va;
      bv = (qb.size() != 0) || vb;
      if (av && bv) begin
        if (va) qa.push_back(a);
        if (vb) qb.push_back(b);
        ha = qa.pop_front();
        hb = qb.pop_front();
        m_out_a = ha; m_out_b = hb; m_dav = 1'b1;
      end else begin
        m_dav = 1'b0;
        if (va) begin
          if (qa.size() < DEPTH) qa.push_back(a);
          else m_ovf_a = 1'b1;
        end
        if (vb) begin
          if (qb.size() < DEPTH) qb.push_back(b);
          else m_ovf_b = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model.dav", longint'(dav), longint'(m_dav));
      chk("model.out_a", longint'(out_a), longint'(m_out_a));
      chk("model.out_b", longint'(out_b), longint'(m_out_b));
      chk("model.level_a", longint'(level_a), longint'(qa.size()));
      chk("model.level_b", longint'(level_b), longint'(qb.size()));
      chk("model.ovf_a", longint'(overflow_a), longint'(m_ovf_a));
      chk("model.ovf_b", longint'(overflow_b), longint'(m_ovf_b));
    end
  end

  task automatic drive(input bit iva, input logic [WIDTH-1:0] ia,
                       input bit ivb, input logic [WIDTH-1:0] ib);
    va = iva; a = ia; vb = ivb; b = ib;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    idle(2);
    chk("rst.dav", longint'(dav), 64'd0);
    chk("rst.out_a", longint'(out_a), 64'd0);
    chk("rst.level_a", longint'(level_a), 64'd0);
    chk("rst.ovf_a", longint'(overflow_a), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Simultaneous arrival with empty FIFOs
    drive(1'b1, 32'h3F800000, 1'b1, 32'h40000000);
    chk("sim.dav", longint'(dav), 64'd1);
    chk("sim.out_a", longint'(out_a), 64'h3F800000);
    chk("sim.out_b", longint'(out_b), 64'h40000000);
    chk("sim.level_a", longint'(level_a), 64'd0);
    idle(1);
    chk("sim.dav_drop", longint'(dav), 64'd0);
    chk("sim.hold_a", longint'(out_a), 64'h3F800000);

    // Skew: A leads by five cycles
    drive(1'b1, 32'd1, 1'b0, 32'h0);
    drive(1'b1, 32'd2, 1'b0, 32'h0);
    drive(1'b1, 32'd3, 1'b0, 32'h0);
    chk("skew.level3", longint'(level_a), 64'd3);
    chk("skew.nodav", longint'(dav), 64'd0);
    idle(2);
    drive(1'b0, 32'h0, 1'b1, 32'd10);
    chk("skew.p1a", longint'(out_a), 64'd1);
    chk("skew.p1b", longint'(out_b), 64'd10);
    chk("skew.level2", longint'(level_a), 64'd2);
    drive(1'b0, 32'h0, 1'b1, 32'd20);
    chk("skew.level1", longint'(level_a), 64'd1);
    drive(1'b0, 32'h0, 1'b1, 32'd30);
    chk("skew.p3a", longint'(out_a), 64'd3);
    chk("skew.p3b", longint'(out_b), 64'd30);
    chk("skew.level0", longint'(level_a), 64'd0);
    idle(2);

    // Continuous streams, B starting four cycles late
    for (int c = 0; c < 104; c++) begin
      drive(c < 100, 32'(32'd100 + 32'(c)), c >= 4, 32'(32'd200 + 32'(c) - 32'd4));
      if (c == 50) begin
        chk("cont.level4", longint'(level_a), 64'd4);
        chk("cont.dav", longint'(dav), 64'd1);
        chk("cont.pair_a", longint'(out_a), 64'd146);
        chk("cont.pair_b", longint'(out_b), 64'd246);
      end
    end
    chk("cont.last_a", longint'(out_a), 64'd199);
    chk("cont.last_b", longint'(out_b), 64'd299);
    chk("cont.drained", longint'(level_a), 64'd0);
    idle(1);

    // Overflow on A: 17 words into a 16-deep FIFO
    for (int k = 1; k <= 17; k++) drive(1'b1, 32'(32'h500 + 32'(k)), 1'b0, 32'h0);
    chk("ovf.flag", longint'(overflow_a), 64'd1);
    chk("ovf.level16", longint'(level_a), 64'd16);
    drive(1'b0, 32'h0, 1'b1, 32'hB01);
    chk("ovf.first_a", longint'(out_a), 64'h501);
    for (int k = 2; k <= 16; k++) drive(1'b0, 32'h0, 1'b1, 32'(32'hB00 + 32'(k)));
    chk("ovf.last_a", longint'(out_a), 64'h510);
    chk("ovf.sticky", longint'(overflow_a), 64'd1);
    chk("ovf.empty", longint'(level_a), 64'd0);

    // Flush clears the sticky flag; then full FIFO with pop+push each cycle
    flush = 1'b1; idle(1); flush = 1'b0;
    chk("flush.ovf_clr", longint'(overflow_a), 64'd0);
    for (int k = 0; k < 16; k++) drive(1'b1, 32'(32'h600 + 32'(k)), 1'b0, 32'h0);
    for (int k = 0; k < 20; k++) drive(1'b1, 32'(32'h610 + 32'(k)), 1'b1, 32'(32'h700 + 32'(k)));
    chk("full.no_ovf", longint'(overflow_a), 64'd0);
    chk("full.level16", longint'(level_a), 64'd16);
    chk("full.pair_a", longint'(out_a), 64'h613);
    for (int k = 20; k < 36; k++) drive(1'b0, 32'h0, 1'b1, 32'(32'h700 + 32'(k)));
    chk("full.drained", longint'(level_a), 64'd0);

    // Overflow on B side, then flush
    for (int k = 0; k < 18; k++) drive(1'b0, 32'h0, 1'b1, 32'(32'h800 + 32'(k)));
    chk("ovfb.flag", longint'(overflow_b), 64'd1);
    chk("ovfb.level16", longint'(level_b), 64'd16);
    flush = 1'b1; idle(1); flush = 1'b0;

    // Flush with a B word present in the same cycle
    for (int k = 0; k < 5; k++) drive(1'b1, 32'(32'h900 + 32'(k)), 1'b0, 32'h0);
    chk("fl.level5", longint'(level_a), 64'd5);
    flush = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'hDEAD);
    flush = 1'b0;
    chk("fl.level0", longint'(level_a), 64'd0);
    chk("fl.nodav", longint'(dav), 64'd0);
    chk("fl.levelb0", longint'(level_b), 64'd0);
    drive(1'b1, 32'h77, 1'b0, 32'h0);
    chk("fl.unpaired", longint'(dav), 64'd0);
    drive(1'b0, 32'h0, 1'b1, 32'h88);
    chk("fl.pair_a", longint'(out_a), 64'h77);
    chk("fl.pair_b", longint'(out_b), 64'h88);

    // Reset mid-stream with inputs active
    for (int k = 0; k < 3; k++) drive(1'b1, 32'(32'hA00 + 32'(k)), 1'b0, 32'h0);
    rst_n = 1'b0;
    drive(1'b1, 32'hAAA, 1'b1, 32'hBBB);
    rst_n = 1'b1;
    chk("mrst.out_a", longint'(out_a), 64'd0);
    chk("mrst.out_b", longint'(out_b), 64'd0);
    chk("mrst.dav", longint'(dav), 64'd0);
    chk("mrst.level_a", longint'(level_a), 64'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
